// File: rtl/chain_mixer_pkg.sv
// chain_mixer_pkg: shared state encoding, stage index width helper and default count width
package chain_mixer_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, PRIME, DISPENSE, SETTLE, DONE} seq_state_t;
  function automatic int stage_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/chain_mixer_dwell_timer.sv
// chain_mixer_dwell_timer: loadable down-counter timing one valve phase, zero load clamped to one cycle
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : strobe, restarts the phase with load_val cycles
//   load_val   : phase length in cycles (0 treated as 1)
//   expired    : high during the last cycle of the phase
module chain_mixer_dwell_timer
  import chain_mixer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] r_cnt;
  // Holding length-1 makes the phase last exactly max(load_val,1) cycles.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (load) r_cnt <= (load_val == '0) ? '0 : load_val - ONE;
    else if (r_cnt != '0) r_cnt <= r_cnt - ONE;
  assign expired = r_cnt == '0;
endmodule

// File: rtl/chain_mixer_inlet_seq.sv
// chain_mixer_inlet_seq: valve sequencer priming j0 then dispensing k0..k(N-1) with settle gaps
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, abort   : sequence request (IDLE only) and termination
//   dwell_cycles   : open time per inlet; settle_cycles : closed gap after each dispense
//   main_valve     : carrier inlet j0; side_valve : one-hot side inlet enables
//   stage_idx      : current stage; busy/done/aborted : status, done/aborted are one-cycle pulses
module chain_mixer_inlet_seq
  import chain_mixer_pkg::*;
#(
  parameter int N_STAGES = 16,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CNT_W-1:0]              dwell_cycles,
  input  logic [CNT_W-1:0]              settle_cycles,
  output logic                          main_valve,
  output logic [N_STAGES-1:0]           side_valve,
  output logic [stage_w(N_STAGES)-1:0]  stage_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted
);
  localparam int SW = stage_w(N_STAGES);
  localparam logic [SW-1:0] LAST = SW'(N_STAGES - 1);
  localparam logic [SW-1:0] ONE = SW'(1);
  seq_state_t r_state, w_nxt;
  logic [SW-1:0] r_stage, w_nxt_stage;
  logic [CNT_W-1:0] r_dwell, r_settle, w_load_val;
  logic w_load, w_expired, w_abort, w_go;
  logic [N_STAGES-1:0] w_onehot;
  chain_mixer_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(w_load), .load_val(w_load_val), .expired(w_expired)
  );
  assign w_go = r_state == IDLE && start && !abort;
  assign w_abort = abort && (r_state inside {PRIME, DISPENSE, SETTLE});
  // Next-state logic; outputs below are registered from the next state so they are Moore.
  always_comb begin
    w_nxt = r_state;
    w_nxt_stage = r_stage;
    w_load = 1'b0;
    w_load_val = r_dwell;
    case (r_state)
      IDLE: if (w_go) begin
        w_nxt = PRIME;
        w_load = 1'b1;
        w_load_val = dwell_cycles;
      end
      PRIME: if (w_expired) begin
        w_nxt = DISPENSE;
        w_nxt_stage = '0;
        w_load = 1'b1;
      end
      DISPENSE: if (w_expired) begin
        w_nxt = SETTLE;
        w_load = 1'b1;
        w_load_val = r_settle;
      end
      SETTLE: if (w_expired) begin
        w_nxt = (r_stage == LAST) ? DONE : DISPENSE;
        w_nxt_stage = (r_stage == LAST) ? r_stage : r_stage + ONE;
        w_load = r_stage != LAST;
      end
      default: w_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_nxt = IDLE;
      w_load = 1'b0;
    end
    if (w_nxt == IDLE) w_nxt_stage = '0;
  end
  assign w_onehot = {{(N_STAGES-1){1'b0}}, 1'b1} << w_nxt_stage;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_dwell <= '0;
      r_settle <= '0;
      main_valve <= 1'b0;
      side_valve <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_stage <= w_nxt_stage;
      if (w_go) begin
        r_dwell <= dwell_cycles;
        r_settle <= settle_cycles;
      end
      main_valve <= w_nxt inside {PRIME, DISPENSE, SETTLE};
      side_valve <= (w_nxt == DISPENSE) ? w_onehot : '0;
      busy <= w_nxt != IDLE;
      done <= w_nxt == DONE;
      aborted <= w_abort;
    end
  assign stage_idx = r_stage;
endmodule
